// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states (IDLE, GAP, DRIVE)
//   DIGIT_W      : bits per hex digit
//   MAX_DIGITS   : largest supported digit count
//   idx_width()  : digit-index register width for a given digit count
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  // A single-digit display still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero blank mask generator (purely combinational).
//   digits  in  DIGIT_W*NUM_DIGITS  packed hex digits, digit 0 rightmost
//   dp_bits in  NUM_DIGITS          decimal-point requests
//   lz_en   in  1                   suppression enable
//   blank   out NUM_DIGITS          1 = digit is dark during its slot
module seven_seg_lz_mask
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         dp_bits,
  input  logic                          lz_en,
  output logic [NUM_DIGITS-1:0]         blank
);

  logic zero_run;

  // Walk from the most significant digit down; a digit is a leading zero
  // only while every digit above it (and itself) is zero with no dp lit.
  // Digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (digits[i*DIGIT_W +: DIGIT_W] == '0) && !dp_bits[i];
      blank[i] = lz_en && zero_run;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a common-cathode seven-seg display.
//   clk        in  1             system clock
//   rst        in  1             synchronous reset, active-high
//   en         in  1             scan enable; low forces IDLE next cycle
//   lz_en      in  1             leading-zero suppression enable
//   din        in  4*NUM_DIGITS  packed hex value, digit 0 rightmost
//   dp_in      in  NUM_DIGITS    decimal-point request per digit
//   digit_sel  out NUM_DIGITS    one-hot active-high digit drive
//   nibble     out 4             current digit value to decoder din
//   nib_en     out 1             decoder enable
//   dp         out 1             decimal point for the current digit
//   frame_tick out 1             pulse in the cycle a new snapshot is taken
// Each slot is SCAN_DIV cycles: BLANK_CYCLES dark, then the digit driven.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          lz_en,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [DIGIT_W-1:0]            nibble,
  output logic                          nib_en,
  output logic                          dp,
  output logic                          frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // With no dark gap the slot boundary goes straight back into DRIVE.
  localparam scan_state_t SLOT_START = (BLANK_CYCLES > 0) ? GAP : DRIVE;

  scan_state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             load;

  logic [DIGIT_W*NUM_DIGITS-1:0] snap_din, snap_din_n;
  logic [NUM_DIGITS-1:0]         snap_dp, snap_dp_n;
  logic [NUM_DIGITS-1:0]         snap_blank, snap_blank_n;
  logic [NUM_DIGITS-1:0]         lz_blank;

  logic [NUM_DIGITS-1:0] digit_sel_n;
  logic [DIGIT_W-1:0]    nibble_n;
  logic                  nib_en_n;
  logic                  dp_n;

  seven_seg_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .digits (din),
    .dp_bits(dp_in),
    .lz_en  (lz_en),
    .blank  (lz_blank)
  );

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      snap_din   <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      digit_sel  <= '0;
      nibble     <= '0;
      nib_en     <= 1'b0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      snap_din   <= snap_din_n;
      snap_dp    <= snap_dp_n;
      snap_blank <= snap_blank_n;
      digit_sel  <= digit_sel_n;
      nibble     <= nibble_n;
      nib_en     <= nib_en_n;
      dp         <= dp_n;
      frame_tick <= load;
    end
  end

  // Next-state logic. load marks every entry into slot 0, which is the
  // only point where the snapshot changes, so a frame never tears.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    load    = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SLOT_START;
          idx_n   = '0;
          cnt_n   = '0;
          load    = 1'b1;
        end
        GAP: begin
          cnt_n = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_n = DRIVE;
        end
        DRIVE: begin
          if (cnt == DIV_LAST) begin
            cnt_n   = '0;
            state_n = SLOT_START;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              load  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign snap_din_n   = load ? din      : snap_din;
  assign snap_dp_n    = load ? dp_in    : snap_dp;
  assign snap_blank_n = load ? lz_blank : snap_blank;

  // Output decode from the upcoming state so the registered outputs line
  // up with the state they describe. nibble holds through gaps and
  // blanked slots so the decoder input does not toggle needlessly.
  always_comb begin
    digit_sel_n = '0;
    nibble_n    = nibble;
    nib_en_n    = 1'b0;
    dp_n        = 1'b0;
    case (state_n)
      IDLE: nibble_n = '0;
      DRIVE: begin
        if (!snap_blank_n[idx_n]) begin
          digit_sel_n = NUM_DIGITS'(1) << idx_n;
          nibble_n    = snap_din_n[idx_n*DIGIT_W +: DIGIT_W];
          nib_en_n    = 1'b1;
          dp_n        = snap_dp_n[idx_n];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  typedef struct {
    int       cyc;
    logic [3:0] sel;
    logic [3:0] nib;
    logic     ne;
    logic     dp;
    logic     ft;
    bit       chk_nib;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1, lz1, en2, lz2;
  logic [15:0] din1, din2;
  logic [3:0]  dpi1, dpi2;
  logic [3:0]  sel1, sel2, nib1, nib2;
  logic        ne1, ne2, dp1, dp2, ft1, ft2;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .lz_en(lz1), .din(din1), .dp_in(dpi1),
    .digit_sel(sel1), .nibble(nib1), .nib_en(ne1), .dp(dp1), .frame_tick(ft1)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .lz_en(lz2), .din(din2), .dp_in(dpi2),
    .digit_sel(sel2), .nibble(nib2), .nib_en(ne2), .dp(dp2), .frame_tick(ft2)
  );

  task automatic push(input int which, input int c, input logic [3:0] s, input logic [3:0] n,
                      input logic ne, input logic dpv, input logic ft, input bit cn);
    exp_t e;
    e.cyc = c; e.sel = s; e.nib = n; e.ne = ne; e.dp = dpv; e.ft = ft; e.chk_nib = cn;
    if (which == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // One 4-cycle slot of dut1: a dark gap cycle, then three drive cycles.
  task automatic slot1(input int start, input int d, input logic [3:0] n, input logic dpv,
                       input bit blanked, input logic [3:0] held);
    push(1, start, 4'b0000, 4'h0, 1'b0, 1'b0, (d == 0), 1'b0);
    for (int k = 1; k < 4; k++) begin
      if (blanked) push(1, start + k, 4'b0000, held, 1'b0, 1'b0, 1'b0, 1'b1);
      else         push(1, start + k, 4'(1 << d), n, 1'b1, dpv, 1'b0, 1'b1);
    end
  endtask

  task automatic frame1(input int start, input logic [15:0] v);
    for (int d = 0; d < 4; d++) slot1(start + 4 * d, d, v[4*d +: 4], 1'b0, 1'b0, 4'h0);
  endtask

  // dut2 has no gap: each digit driven for all four cycles of its slot.
  task automatic frame2(input int start, input logic [15:0] v);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 4; k++)
        push(2, start + 4 * d + k, 4'(1 << d), v[4*d +: 4], 1'b1, 1'b0,
             (d == 0 && k == 0), 1'b1);
  endtask

  task automatic compare(input int which, input exp_t e, input logic [3:0] s,
                         input logic [3:0] n, input logic ne, input logic dpv, input logic ft);
    bit ok;
    ok = (s === e.sel) && (ne === e.ne) && (dpv === e.dp) && (ft === e.ft) &&
         (!e.chk_nib || (n === e.nib));
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL dut%0d cyc %0d: got sel=%b nib=%h ne=%b dp=%b ft=%b, need sel=%b nib=%h ne=%b dp=%b ft=%b",
               which, cyc, s, n, ne, dpv, ft, e.sel, e.nib, e.ne, e.dp, e.ft);
    end
  endtask

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].cyc == cyc) begin
      e1 = q1.pop_front();
      compare(1, e1, sel1, nib1, ne1, dp1, ft1);
    end
    while (q2.size() > 0 && q2[0].cyc == cyc) begin
      e2 = q2.pop_front();
      compare(2, e2, sel2, nib2, ne2, dp2, ft2);
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en1 = 1'b1; lz1 = 1'b0; din1 = 16'h1234; dpi1 = 4'b0000;
    en2 = 1'b1; lz2 = 1'b0; din2 = 16'h1234; dpi2 = 4'b0000;

    // Reset holds every output low despite en=1.
    for (int c = 1; c <= 3; c++) begin
      push(1, c, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push(2, c, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    // Basic scan and the no-tearing frame for dut1.
    frame1(4, 16'h1234);
    frame1(20, 16'h1234);
    frame1(36, 16'hABCD);
    // dut2 scans uninterrupted for the whole run.
    for (int f = 0; f < 8; f++) frame2(4 + 16 * f, 16'h1234);

    wait_until(3);
    rst = 1'b0;

    // Mid-frame change during digit 1 drive of the frame starting at 20.
    wait_until(25);
    din1 = 16'hABCD;

    wait_until(37);
    din1 = 16'h0050; lz1 = 1'b1;
    slot1(52, 0, 4'h0, 1'b0, 1'b0, 4'h0);
    slot1(56, 1, 4'h5, 1'b0, 1'b0, 4'h0);
    slot1(60, 2, 4'h0, 1'b0, 1'b1, 4'h5);
    slot1(64, 3, 4'h0, 1'b0, 1'b1, 4'h5);

    wait_until(53);
    din1 = 16'h0000;
    slot1(68, 0, 4'h0, 1'b0, 1'b0, 4'h0);
    slot1(72, 1, 4'h0, 1'b0, 1'b1, 4'h0);
    slot1(76, 2, 4'h0, 1'b0, 1'b1, 4'h0);
    slot1(80, 3, 4'h0, 1'b0, 1'b1, 4'h0);

    wait_until(69);
    din1 = 16'h0050; dpi1 = 4'b0100;
    slot1(84, 0, 4'h0, 1'b0, 1'b0, 4'h0);
    slot1(88, 1, 4'h5, 1'b0, 1'b0, 4'h0);
    slot1(92, 2, 4'h0, 1'b1, 1'b0, 4'h0);
    slot1(96, 3, 4'h0, 1'b0, 1'b1, 4'h0);

    wait_until(85);
    din1 = 16'h1234; lz1 = 1'b0; dpi1 = 4'b0000;
    slot1(100, 0, 4'h4, 1'b0, 1'b0, 4'h0);
    slot1(104, 1, 4'h3, 1'b0, 1'b0, 4'h0);
    push(1, 108, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1, 109, 4'b0100, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    push(1, 110, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1, 111, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Drop en during digit 2 drive, then restart a fresh frame.
    wait_until(109);
    en1 = 1'b0;
    wait_until(111);
    en1 = 1'b1;
    frame1(112, 16'h1234);
    push(1, 128, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    wait_until(134);
    tests++;
    if (q1.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL drain: unchecked entries dut1=%0d dut2=%0d, need 0 and 0", q1.size(), q2.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display.
- Snapshots a packed hex value once per frame and selects one digit at a time.
- Drives that digit's nibble and enable into the downstream seven-segment decoder (din/en inputs), and drives the one-hot digit-select lines to the display.
- Inserts a dark gap between digits to prevent ghosting; optionally suppresses leading zeros.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8).
- SCAN_DIV, 100000, clock cycles per digit slot (legal >= 2).
- BLANK_CYCLES, 1000, dark cycles at the start of each slot (legal 0..SCAN_DIV-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  scan enable.
- lz_en  in  1  leading-zero suppression enable.
- din  in  4*NUM_DIGITS  packed hex value; digit i = din[4i+3:4i]; digit 0 is the rightmost digit.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- digit_sel  out  NUM_DIGITS  one-hot, active-high digit drive.
- nibble  out  4  current digit value, to decoder din.
- nib_en  out  1  decoder enable, to decoder en.
- dp  out  1  decimal point for the current digit.
- frame_tick  out  1  one-cycle pulse marking each snapshot.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - All outputs are registered.
  - Reset values: digit_sel=0, nibble=0, nib_en=0, dp=0, frame_tick=0. Internal state: state=IDLE, idx=0, cnt=0, snapshot=0.
- State machine (IDLE, GAP, DRIVE):
  - IDLE: all outputs 0. If en=1, go to GAP (or DRIVE when BLANK_CYCLES=0) with idx=0, cnt=0, load snapshot.
  - GAP: digit_sel=0, nib_en=0, dp=0. cnt increments each cycle. When cnt=BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: cnt continues. When cnt=SCAN_DIV-1, set cnt=0 and idx=idx+1, wrapping NUM_DIGITS-1 to 0. Go to GAP (or stay in DRIVE when BLANK_CYCLES=0).
- Slot length: each slot is exactly SCAN_DIV cycles, BLANK_CYCLES dark followed by SCAN_DIV-BLANK_CYCLES driven. A full frame is NUM_DIGITS*SCAN_DIV cycles.
- Snapshot:
  - din, dp_in and the leading-zero blank mask are captured together in the cycle that enters slot 0 (IDLE exit or wrap from idx NUM_DIGITS-1).
  - frame_tick is 1 in exactly that cycle.
  - Changes to din mid-frame are not visible until the next frame; no tearing.
- Drive outputs during DRIVE of a non-blanked digit:
  - digit_sel = 1<<idx.
  - nibble = snapshot digit idx.
  - nib_en = 1.
  - dp = snapshot dp bit idx.
- Blanked digit during DRIVE: digit_sel=0, nib_en=0, dp=0; nibble holds its value.
- Leading-zero mask:
  - When lz_en=1, digit i>0 is blanked if snapshot digits i..NUM_DIGITS-1 are all zero and none of dp_in[i..NUM_DIGITS-1] is set.
  - Digit 0 is never blanked. lz_en is sampled with the snapshot.
- en deasserted in any state: the next cycle is IDLE, outputs are 0, idx=0, cnt=0. Re-assertion starts a fresh frame at digit 0 with a new snapshot and frame_tick.
- rst has priority over en.
- Width rules:
  - cnt width = $clog2(SCAN_DIV).
  - idx width = max(1,$clog2(NUM_DIGITS)).
  - No arithmetic overflow beyond the wrap points above.

Decomposition:
- Package seven_seg_pkg:
  - scan_state_t enum {IDLE, GAP, DRIVE}.
  - DIGIT_W=4.
  - MAX_DIGITS=8.
- Sub-module seven_seg_lz_mask: combinational, maps the packed digits, dp bits and lz_en to a NUM_DIGITS blank mask. Instantiated once, feeding the snapshot register.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1 unless noted):
- Reset: rst=1 for 3 cycles with en=1, din=16'h1234 -> all outputs 0. First cycle after release has frame_tick=1 and digit_sel=0.
- Basic scan: din=16'h1234, lz_en=0, dp_in=0 -> per slot, 1 cycle digit_sel=0 then 3 cycles digit_sel=0001/0010/0100/1000 with nibble=4/3/2/1 and nib_en=1. frame_tick every 16 cycles.
- No tearing: change din to 16'hABCD during digit 1's DRIVE -> digits 2,3 still show 2,1. The next frame shows D,C,B,A.
- Leading-zero suppression:
  - lz_en=1, din=16'h0050 -> digits 0,1 driven with 0,5; digits 2,3 give digit_sel=0, nib_en=0.
  - din=16'h0000 -> only digit 0 is driven, nibble 0.
  - din=16'h0050 with dp_in=4'b0100 -> digit 2 is driven with nibble 0 and dp=1.
- en drop: deassert en during digit 2's DRIVE -> next cycle all outputs 0. Re-assert -> frame_tick=1, scan restarts at digit 0 after 1 gap cycle.
- BLANK_CYCLES=0 configuration: din=16'h1234 -> digit_sel is continuously one-hot, each digit for 4 cycles, and never 0 while en=1.
